// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the key-event levels handed to the control unit.
// master: the scanner (drives rows and events, senses cols).
// slave: board/consumer side.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] num;
    logic       numPressed;
    logic [2:0] opt;
    logic       optPressed;
    logic       submit;

    modport master (
        output rows, num, numPressed, opt, optPressed, submit,
        input  cols
    );

    modport slave (
        input  rows, num, numPressed, opt, optPressed, submit,
        output cols
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column synchronizer, frame debounce and
// commit FSM producing num/opt/submit levels for the control unit.
// Optional digit auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 5,
    parameter int unsigned REPEAT_FRAMES   = 150
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
    localparam int unsigned      DB_W     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_FRAMES);
    localparam logic [4:0]       KEY_NONE = 5'd16;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned      REP_W      = $clog2(REPEAT_FRAMES + 1);
    localparam int unsigned      REP_PERIOD = REPEAT_FRAMES / 4;
    localparam logic [REP_W-1:0] REP_MAX    = REP_W'(REPEAT_FRAMES);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_FRAMES - REP_PERIOD);
`endif

    // Sampling needs the synchronizer settled inside a row period; repeat
    // cadence needs at least two frames between drops.
    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 8) begin : g_bad_params
        $error("keypad_scanner: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_GAP} state_t;

    logic [3:0]       r_cols_s1, r_cols_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_rows;
    logic [11:0]      r_frame;
    logic [DB_W-1:0]  r_db_cnt;
    logic [4:0]       r_last_key;
    state_t           r_state;
    logic [3:0]       r_key, r_pend, r_num;
    logic [2:0]       r_opt;
    logic             r_np, r_op, r_sub;

    logic             w_div_tc, w_frame_end;
    logic [1:0]       w_row_nxt;
    logic [15:0]      w_pressed;
    logic [1:0]       w_hits;
    logic [3:0]       w_code;
    logic             w_multi;
    logic [4:0]       w_result;
    logic [DB_W-1:0]  w_db_cnt_nxt;
    logic [4:0]       w_last_nxt;
    logic             w_stable;
    state_t           w_state_nxt;
    logic [3:0]       w_key_nxt, w_pend_nxt, w_num_nxt;
    logic [2:0]       w_opt_nxt;
    logic             w_np_nxt, w_op_nxt, w_sub_nxt;
    logic             w_commit;
    logic [3:0]       w_commit_key;
`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0] r_rep, w_rep_nxt;
`endif

    assign w_div_tc    = (r_div == DIV_TC);
    assign w_frame_end = w_div_tc && (r_row == 2'd3);
    assign w_row_nxt   = r_row + 2'd1;
    // Row 3 is not stored: it is taken live from the synchronizer at frame end.
    assign w_pressed   = ~{r_cols_s2, r_frame};

    // Classify the completed frame: none, a single code, or multiple keys
    always_comb begin
        w_hits = 2'd0;
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_pressed[i]) begin
                if (w_hits != 2'd2) w_hits = w_hits + 2'd1;
                w_code = 4'(i);
            end
        end
        w_multi  = (w_hits == 2'd2);
        w_result = (w_hits == 2'd0) ? KEY_NONE : {1'b0, w_code};
    end

    // Debounce counter update for the frame being closed
    always_comb begin
        w_db_cnt_nxt = r_db_cnt;
        w_last_nxt   = r_last_key;
        if (w_multi) begin
            w_db_cnt_nxt = '0;
        end else if (w_result == r_last_key) begin
            if (r_db_cnt != DB_MAX) w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end else begin
            w_db_cnt_nxt = DB_W'(1);
            w_last_nxt   = w_result;
        end
        w_stable = !w_multi && (w_db_cnt_nxt == DB_MAX);
    end

    // Scan divider, row drive, synchronizer and frame accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cols_s1  <= 4'hF;
            r_cols_s2  <= 4'hF;
            r_div      <= '0;
            r_row      <= 2'd0;
            r_rows     <= 4'b1110;
            r_frame    <= 12'hFFF;
            r_db_cnt   <= '0;
            r_last_key <= KEY_NONE;
        end else begin
            r_cols_s1 <= kp.cols;
            r_cols_s2 <= r_cols_s1;
            if (w_div_tc) begin
                r_div  <= '0;
                r_row  <= w_row_nxt;
                r_rows <= ~(4'b0001 << w_row_nxt);
                case (r_row)
                    2'd0:    r_frame[3:0]  <= r_cols_s2;
                    2'd1:    r_frame[7:4]  <= r_cols_s2;
                    2'd2:    r_frame[11:8] <= r_cols_s2;
                    default: ;
                endcase
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_frame_end) begin
                r_db_cnt   <= w_db_cnt_nxt;
                r_last_key <= w_last_nxt;
            end
        end
    end

    // Commit FSM next state and next output levels
    always_comb begin
        w_state_nxt  = r_state;
        w_key_nxt    = r_key;
        w_pend_nxt   = r_pend;
        w_num_nxt    = r_num;
        w_opt_nxt    = r_opt;
        w_np_nxt     = r_np;
        w_op_nxt     = r_op;
        w_sub_nxt    = r_sub;
        w_commit     = 1'b0;
        w_commit_key = '0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt    = r_rep;
`endif
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stable && (w_result != KEY_NONE)) begin
                        w_commit     = 1'b1;
                        w_commit_key = w_result[3:0];
                    end
                end
                ST_HELD: begin
                    if (w_stable && (w_result == KEY_NONE)) begin
                        w_state_nxt = ST_IDLE;
                        {w_np_nxt, w_op_nxt, w_sub_nxt} = 3'b000;
                    end else if (w_stable && (w_result[3:0] != r_key)) begin
                        // Force one low frame so the consumer sees an edge
                        w_state_nxt = ST_GAP;
                        w_pend_nxt  = w_result[3:0];
                        {w_np_nxt, w_op_nxt, w_sub_nxt} = 3'b000;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (r_key < 4'd10) begin
                        w_rep_nxt = r_rep + REP_W'(1);
                        w_np_nxt  = 1'b1;
                        if (w_rep_nxt == REP_MAX) begin
                            w_np_nxt  = 1'b0;
                            w_rep_nxt = REP_RELOAD;
                        end
                    end
`endif
                end
                ST_GAP: begin
                    w_commit     = 1'b1;
                    w_commit_key = r_pend;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_commit) begin
            w_state_nxt = ST_HELD;
            w_key_nxt   = w_commit_key;
            w_np_nxt    = (w_commit_key < 4'd10);
            w_op_nxt    = (w_commit_key >= 4'd10) && (w_commit_key != 4'd15);
            w_sub_nxt   = (w_commit_key == 4'd15);
            if (w_commit_key < 4'd10) w_num_nxt = w_commit_key;
            else if (w_commit_key != 4'd15) w_opt_nxt = 3'(w_commit_key - 4'd9);
`ifdef KEYPAD_REPEAT_EN
            w_rep_nxt   = '0;
`endif
        end
    end

    // Commit state and registered output levels
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_pend  <= '0;
            r_num   <= '0;
            r_opt   <= '0;
            r_np    <= 1'b0;
            r_op    <= 1'b0;
            r_sub   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_pend  <= w_pend_nxt;
            r_num   <= w_num_nxt;
            r_opt   <= w_opt_nxt;
            r_np    <= w_np_nxt;
            r_op    <= w_op_nxt;
            r_sub   <= w_sub_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= w_rep_nxt;
`endif
        end
    end

    assign kp.rows       = r_rows;
    assign kp.num        = r_num;
    assign kp.numPressed = r_np;
    assign kp.opt        = r_opt;
    assign kp.optPressed = r_op;
    assign kp.submit     = r_sub;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed vector table, hand-written corner
// sequences, and random frame-aligned key patterns against a frame-level model.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 8;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int NONE     = 16;
    localparam int MULTI    = 17;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    int          n_checks = 0;
    int          n_errors = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB),
        .REPEAT_FRAMES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp)
    );

    always #5 clk = ~clk;

    // Ideal membrane matrix: a pressed key shorts its column to the driven row
    always_comb begin
        kp.cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.rows[r] && pressed[4*r+c]) kp.cols[c] = 1'b0;
    end

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [3:0]  num;
        logic        np;
        logic [2:0]  opt;
        logic        op;
        logic        sub;
    } vec_t;

    vec_t tbl[20];

    // Frame-level reference model state
    int         m_hist[$];
    int         m_state;   // 0 idle, 1 held, 2 gap
    int         m_key, m_pend, m_n;
    logic [3:0] m_num;
    logic [2:0] m_opt;
    logic       m_np, m_op, m_sub;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] pk(logic [3:0] n, logic np, logic [2:0] o, logic op, logic s);
        return {n, np, o, op, s};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {kp.num, kp.numPressed, kp.opt, kp.optPressed, kp.submit};
    endfunction

    function automatic bit rep_drop(int n);
        return REP_EN && (n >= REP) && (((n - REP) % (REP / 4)) == 0);
    endfunction

    function automatic int frame_result(logic [15:0] p);
        int idx;
        idx = 0;
        if ($countones(p) == 0) return NONE;
        if ($countones(p) > 1) return MULTI;
        for (int i = 0; i < 16; i++) if (p[i]) idx = i;
        return idx;
    endfunction

    task automatic m_reset();
        m_hist.delete();
        m_state = 0; m_key = 0; m_pend = 0; m_n = 0;
        m_num = '0; m_opt = '0; m_np = 0; m_op = 0; m_sub = 0;
    endtask

    task automatic m_commit(input int k);
        m_state = 1; m_key = k; m_n = 0;
        m_np  = (k < 10);
        m_op  = (k >= 10) && (k < 15);
        m_sub = (k == 15);
        if (k < 10) m_num = 4'(k);
        else if (k < 15) m_opt = 3'(k - 9);
    endtask

    // A key is stable when the last DEB frame results are identical and single
    task automatic m_update(input int res);
        bit stable;
        m_hist.push_back(res);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        stable = (res != MULTI) && (m_hist.size() == DEB);
        foreach (m_hist[i]) if (m_hist[i] != res) stable = 0;
        if (m_state == 2) m_commit(m_pend);
        else if (stable && res == NONE) begin
            m_state = 0; m_np = 0; m_op = 0; m_sub = 0;
        end else if (stable && m_state == 0) m_commit(res);
        else if (stable && m_state == 1 && res != m_key) begin
            m_state = 2; m_pend = res; m_np = 0; m_op = 0; m_sub = 0;
        end else if (m_state == 1) begin
            m_n++;
            if (m_key < 10) m_np = !rep_drop(m_n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_b;
        tbl[0]  = '{16'h0080, 2, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0080, 1, 4'd7, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0080, 2, 4'd7, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{16'h0000, 2, 4'd7, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{16'h0000, 1, 4'd7, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{16'h4000, 2, 4'd7, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{16'h4000, 1, 4'd7, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[7]  = '{16'h0000, 3, 4'd7, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[8]  = '{16'h8000, 3, 4'd7, 1'b0, 3'd5, 1'b0, 1'b1};
        tbl[9]  = '{16'h0000, 3, 4'd7, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[10] = '{16'h0024, 4, 4'd7, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1, 4'd7, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[12] = '{16'h0010, 3, 4'd4, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[13] = '{16'h0200, 2, 4'd4, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[14] = '{16'h0200, 1, 4'd4, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[15] = '{16'h0200, 1, 4'd9, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[16] = '{16'h0024, 3, 4'd9, 1'b1, 3'd5, 1'b0, 1'b0};
        tbl[17] = '{16'h0000, 3, 4'd9, 1'b0, 3'd5, 1'b0, 1'b0};
        tbl[18] = '{16'h0400, 3, 4'd9, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[19] = '{16'h0000, 3, 4'd9, 1'b0, 3'd1, 1'b0, 1'b0};

        // Reset and row rotation
        reset   = 1'b0;
        pressed = '0;
        tick(3);
        check("reset_rows", kp.rows, 4'b1110);
        check("reset_outs", dut_outs(), 10'h000);
        reset = 1'b1;
        tick(4);  check("rows_r1", kp.rows, 4'b1101);
        tick(4);  check("rows_r2", kp.rows, 4'b1011);
        tick(4);  check("rows_r3", kp.rows, 4'b0111);
        tick(4);  check("rows_wrap", kp.rows, 4'b1110);

        // Directed vector table, frame aligned
        for (int i = 0; i < 20; i++) begin
            pressed = tbl[i].keys;
            tick(tbl[i].frames * FRAME);
            check($sformatf("tbl%0d", i), dut_outs(),
                  pk(tbl[i].num, tbl[i].np, tbl[i].opt, tbl[i].op, tbl[i].sub));
        end

        // Bouncing key 3: toggles every 10 cycles for four frames, no commit
        for (int k = 0; k < 7; k++) begin
            pressed = (k % 2 == 1) ? 16'h0008 : 16'h0000;
            tick((k == 6) ? 4 : 10);
        end
        check("bounce_hold", dut_outs(), pk(4'd9, 1'b0, 3'd1, 1'b0, 1'b0));
        pressed = 16'h0008;
        tick(2 * FRAME);
        check("bounce_2stable", dut_outs(), pk(4'd9, 1'b0, 3'd1, 1'b0, 1'b0));
        tick(FRAME);
        check("bounce_commit", dut_outs(), pk(4'd3, 1'b1, 3'd1, 1'b0, 1'b0));
        pressed = '0;
        tick(3 * FRAME);
        check("bounce_release", dut_outs(), pk(4'd3, 1'b0, 3'd1, 1'b0, 1'b0));

        // Long digit hold: continuous level, or periodic drops with repeat
        pressed = 16'h0002;
        for (int f = 1; f <= 20; f++) begin
            tick(FRAME);
            exp_b = (f >= DEB) && !rep_drop(f - DEB);
            check($sformatf("hold1_f%0d", f), kp.numPressed, exp_b);
        end
        pressed = '0;
        tick(3 * FRAME);
        check("hold1_release", dut_outs(), pk(4'd1, 1'b0, 3'd1, 1'b0, 1'b0));

        // Long operation hold never repeats
        pressed = 16'h0400;
        for (int f = 1; f <= 20; f++) begin
            tick(FRAME);
            exp_b = (f >= DEB);
            check($sformatf("hold10_f%0d", f), kp.optPressed, exp_b);
        end
        check("hold10_outs", dut_outs(), pk(4'd1, 1'b0, 3'd1, 1'b1, 1'b0));

        // Reset mid-frame while HELD clears everything on the next edge
        tick(5);
        reset   = 1'b0;
        pressed = '0;
        tick(1);
        check("midreset_outs", dut_outs(), 10'h000);
        check("midreset_rows", kp.rows, 4'b1110);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("postreset_outs", dut_outs(), 10'h000);
        tick(FRAME - 3);
        m_reset();
        m_update(NONE);
        check("postreset_frame", dut_outs(), 10'h000);

        // Random frame-aligned patterns against the reference model
        for (int f = 0; f < 200; f++) begin
            int unsigned sel, k1, k2;
            sel = $urandom_range(0, 99);
            k1  = $urandom_range(0, 15);
            k2  = (k1 + 1 + $urandom_range(0, 14)) % 16;
            if (sel >= 60 && sel < 75) pressed = '0;
            else if (sel >= 75 && sel < 95) pressed = 16'(1) << k1;
            else if (sel >= 95) pressed = (16'(1) << k1) | (16'(1) << k2);
            tick(FRAME / 2);
            check($sformatf("rand_mid%0d", f), dut_outs(), pk(m_num, m_np, m_opt, m_op, m_sub));
            tick(FRAME / 2);
            m_update(frame_result(pressed));
            check($sformatf("rand_end%0d", f), dut_outs(), pk(m_num, m_np, m_opt, m_op, m_sub));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
